matrix_coprocessor_seq: RTL and testbench
=========================================

Name: matrix_coprocessor_seq

Overview:
- Sequential, parametrised successor to the single-cycle convolution coprocessor.
- Performs element-wise add, subtract, negate, transpose and convolution on square matrices of 2x2 to MAX_N x MAX_N signed elements.
- Processes one element per clock behind a start/busy/done handshake.
- Sits between the HPS-facing instruction/register interface and the matrix operand buffers. Operands and result use the existing packed flat-vector layout.

Parameters:
- ELEM_W, 8, signed element width in bits.
- MAX_N, 5, maximum matrix dimension. Vector widths are MAX_N*MAX_N*ELEM_W.
- ACC_W, 2*ELEM_W+5, convolution accumulator width. Must be at least 2*ELEM_W+ceil(log2(MAX_N*MAX_N)).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_code  input  3  000 add, 001 sub, 011 transpose(A), 100 negate(A), 111 convolution; others invalid.
- matrix_size  input  2  active N = matrix_size+2 (2..5); values giving N > MAX_N are clamped to MAX_N.
- matrix_a  input  MAX_N*MAX_N*ELEM_W  operand A, packed.
- matrix_b  input  MAX_N*MAX_N*ELEM_W  operand B / kernel, packed.
- busy  output  1  high while an operation is in progress.
- process_Done  output  1  one-cycle completion pulse.
- op_error  output  1  invalid op_code flag for the last operation.
- overflow  output  1  sticky saturation flag for the last operation.
- result_final  output  MAX_N*MAX_N*ELEM_W  result, packed.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- While reset is asserted, all outputs are 0 and the FSM is in IDLE. Assertion mid-operation aborts immediately; no done pulse is produced.
- Layout: element (r,c) occupies bits [(r*MAX_N+c)*ELEM_W +: ELEM_W]. Arithmetic is two's complement signed.
- FSM states:
  - IDLE: busy=0. On start=1 at an edge, latch op_code, N, matrix_a and matrix_b into internal registers. Clear result_final, overflow, op_error and the accumulator; r=c=0; go to EXEC. Operand inputs may change after that edge.
  - EXEC: busy=1. One element (r,c) per edge, row-major, c wraps at N-1 and r then increments. Exactly N*N edges.
    - add/sub/negate: result(r,c) = A±B or -A, written at that edge.
    - transpose: result(c,r) = A(r,c).
    - convolution: acc += A(r,c)*B(r,c). On the last element, result(0,0) = final acc reduced to ELEM_W; all other elements stay 0.
    - invalid op: no writes; op_error=1. EXEC length is unchanged.
    - Elements outside the active N x N region remain 0.
  - DONE: one cycle. process_Done=1, busy=0, then IDLE. result_final, overflow and op_error hold until the next accepted start.
- Latency: start accepted at edge k means process_Done is high during the cycle after edge k+N*N. N=2 gives 4 EXEC edges; N=5 gives 25.
- start while busy or in DONE is ignored and not queued. start held high in IDLE after DONE begins a new operation.
- Width reduction follows SAT_EN (see Optional Feature). Negate of the most negative value is an overflow case.

Optional Feature:
- Macro: MATRIX_COPROC_SAT_EN.
- Defined: every element result and the convolution result saturate to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]. Any clamp sets overflow (sticky for the operation).
- Undefined: results wrap (low ELEM_W bits kept) and overflow is tied to 0.

Test Plan:
- Reset abort: start add N=5, assert reset at EXEC element 7 -> busy, process_Done and result_final go to 0 at once; no done pulse after release.
- Add 2x2 (size=00): A=all 3, B=all 4 -> elements 0,1,5,6 = 8'h07, rest 0. process_Done exactly 5 edges after start; busy high 4 cycles.
- Sub 3x3: A=all -100, B=all 100 -> with SAT_EN, active elements 8'h80 and overflow=1; without it, 8'h38 and overflow=0.
- Convolution: 3x3 A=all 2, B=all 3 -> element 0 = 8'd54, rest 0. 5x5 A=B=all 127 -> with SAT_EN, element 0 = 8'h7F and overflow=1.
- Transpose 4x4: A(0,1)=5, A(3,2)=-7 -> result(1,0)=5, result(2,3)=8'hF9. A second start pulse during EXEC is ignored, giving exactly one done pulse.
- Invalid op_code 3'b010, N=2 -> op_error=1, result_final=0, process_Done after 5 edges.

Source files
------------

// File: rtl/matrix_coprocessor_seq.sv
// Sequential matrix coprocessor: add/sub/negate/transpose/convolution, one element per clock.
// Build option MATRIX_COPROC_SAT_EN: saturate results and report overflow; otherwise results wrap.
module matrix_coprocessor_seq #(
    parameter int ELEM_W = 8,
    parameter int MAX_N  = 5,
    parameter int ACC_W  = 2*ELEM_W+5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [2:0]                      op_code,
    input  logic [1:0]                      matrix_size,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0]   matrix_a,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0]   matrix_b,
    output logic                            busy,
    output logic                            process_Done,
    output logic                            op_error,
    output logic                            overflow,
    output logic [MAX_N*MAX_N*ELEM_W-1:0]   result_final
);

    localparam int NUM_EL = MAX_N*MAX_N;
    localparam int VEC_W  = NUM_EL*ELEM_W;
    localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_TRN  = 3'b011;
    localparam logic [2:0] OP_NEG  = 3'b100;
    localparam logic [2:0] OP_CONV = 3'b111;

`ifdef MATRIX_COPROC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                   state_reg;
    logic [2:0]               op_reg;
    logic [3:0]               n_reg;
    logic [3:0]               r_reg;
    logic [3:0]               c_reg;
    logic [VEC_W-1:0]         a_reg;
    logic [VEC_W-1:0]         b_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [ELEM_W-1:0]        res_arr_reg [NUM_EL];
    logic                     busy_reg;
    logic                     done_reg;
    logic                     op_error_reg;
    logic                     overflow_reg;

    logic signed [ELEM_W-1:0] a_arr [NUM_EL];
    logic signed [ELEM_W-1:0] b_arr [NUM_EL];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EL; gi++) begin : g_el
            assign a_arr[gi] = a_reg[gi*ELEM_W +: ELEM_W];
            assign b_arr[gi] = b_reg[gi*ELEM_W +: ELEM_W];
            assign result_final[gi*ELEM_W +: ELEM_W] = res_arr_reg[gi];
        end
    endgenerate

    assign busy         = busy_reg;
    assign process_Done = done_reg;
    assign op_error     = op_error_reg;
    assign overflow     = overflow_reg;

    // Requested dimension is clamped so a small MAX_N build never walks off the array.
    logic [3:0] n_req;
    logic [3:0] n_start;
    assign n_req   = {2'b00, matrix_size} + 4'd2;
    assign n_start = (n_req > MAX_N4) ? MAX_N4 : n_req;

    logic [IDX_W-1:0] idx_rc;
    logic [IDX_W-1:0] idx_cr;
    logic             last_el;
    logic             c_wrap;
    assign idx_rc  = IDX_W'(r_reg) * IDX_W'(MAX_N) + IDX_W'(c_reg);
    assign idx_cr  = IDX_W'(c_reg) * IDX_W'(MAX_N) + IDX_W'(r_reg);
    assign c_wrap  = (c_reg == n_reg - 4'd1);
    assign last_el = c_wrap && (r_reg == n_reg - 4'd1);

    logic signed [ELEM_W-1:0]   a_el;
    logic signed [ELEM_W-1:0]   b_el;
    logic signed [2*ELEM_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_next;
    logic [ELEM_W-1:0]          wr_val;
    logic [IDX_W-1:0]           wr_idx;
    logic                       wr_en;
    logic                       wr_clamp;
    logic                       op_valid;
`ifdef MATRIX_COPROC_SAT_EN
    logic signed [ACC_W-1:0]    ext_val;
`endif

    always_comb begin
        a_el     = a_arr[idx_rc];
        b_el     = b_arr[idx_rc];
        prod     = a_el * b_el;
        acc_next = acc_reg + ACC_W'(prod);
        wr_val   = '0;
        wr_idx   = idx_rc;
        wr_en    = 1'b0;
        wr_clamp = 1'b0;
        op_valid = 1'b1;
`ifdef MATRIX_COPROC_SAT_EN
        // Full-precision value first, then clamp into the element range.
        ext_val = '0;
        case (op_reg)
            OP_ADD:  begin ext_val = ACC_W'(a_el) + ACC_W'(b_el); wr_en = 1'b1; end
            OP_SUB:  begin ext_val = ACC_W'(a_el) - ACC_W'(b_el); wr_en = 1'b1; end
            OP_NEG:  begin ext_val = -ACC_W'(a_el);               wr_en = 1'b1; end
            OP_TRN:  begin ext_val = ACC_W'(a_el); wr_idx = idx_cr; wr_en = 1'b1; end
            OP_CONV: begin ext_val = acc_next; wr_idx = '0; wr_en = last_el; end
            default: op_valid = 1'b0;
        endcase
        if (ext_val > SAT_MAX) begin
            wr_val   = SAT_MAX[ELEM_W-1:0];
            wr_clamp = 1'b1;
        end else if (ext_val < SAT_MIN) begin
            wr_val   = SAT_MIN[ELEM_W-1:0];
            wr_clamp = 1'b1;
        end else begin
            wr_val   = ext_val[ELEM_W-1:0];
        end
`else
        case (op_reg)
            OP_ADD:  begin wr_val = a_el + b_el; wr_en = 1'b1; end
            OP_SUB:  begin wr_val = a_el - b_el; wr_en = 1'b1; end
            OP_NEG:  begin wr_val = -a_el;       wr_en = 1'b1; end
            OP_TRN:  begin wr_val = a_el; wr_idx = idx_cr; wr_en = 1'b1; end
            OP_CONV: begin wr_val = acc_next[ELEM_W-1:0]; wr_idx = '0; wr_en = last_el; end
            default: op_valid = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            n_reg        <= '0;
            r_reg        <= '0;
            c_reg        <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            op_error_reg <= 1'b0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < NUM_EL; i++) res_arr_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg       <= op_code;
                        n_reg        <= n_start;
                        a_reg        <= matrix_a;
                        b_reg        <= matrix_b;
                        r_reg        <= '0;
                        c_reg        <= '0;
                        acc_reg      <= '0;
                        op_error_reg <= 1'b0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= EXEC;
                        for (int i = 0; i < NUM_EL; i++) res_arr_reg[i] <= '0;
                    end
                end
                EXEC: begin
                    if (wr_en) res_arr_reg[wr_idx] <= wr_val;
                    overflow_reg <= overflow_reg | (wr_en & wr_clamp);
                    if (!op_valid) op_error_reg <= 1'b1;
                    if (op_reg == OP_CONV) acc_reg <= acc_next;
                    if (last_el) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (c_wrap) begin
                        c_reg <= '0;
                        r_reg <= r_reg + 4'd1;
                    end else begin
                        c_reg <= c_reg + 4'd1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_coprocessor_seq.sv
// Scoreboard bench for matrix_coprocessor_seq: driver pushes model results, monitor checks on each done pulse.
`timescale 1ns/1ps
module tb_matrix_coprocessor_seq;

    localparam int EW   = 8;
    localparam int MN   = 5;
    localparam int NE   = MN*MN;
    localparam int VW   = NE*EW;
    localparam int EMAX = 127;
    localparam int EMIN = -128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op_code = '0;
    logic [1:0]    matrix_size = '0;
    logic [VW-1:0] matrix_a = '0;
    logic [VW-1:0] matrix_b = '0;
    logic          busy;
    logic          process_Done;
    logic          op_error;
    logic          overflow;
    logic [VW-1:0] result_final;

    always #5 clk = ~clk;

    matrix_coprocessor_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_code      (op_code),
        .matrix_size  (matrix_size),
        .matrix_a     (matrix_a),
        .matrix_b     (matrix_b),
        .busy         (busy),
        .process_Done (process_Done),
        .op_error     (op_error),
        .overflow     (overflow),
        .result_final (result_final)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int txn   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [VW-1:0] res;
        logic          err;
        logic          ovf;
        int            done_cyc;
        int            op;
        int            n;
    } exp_t;

    exp_t exp_q[$];
    int   ma[NE];
    int   mb[NE];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int rnd_el();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int reduce(input int v);
`ifdef MATRIX_COPROC_SAT_EN
        if (v > EMAX) return EMAX;
        if (v < EMIN) return EMIN;
        return v;
`else
        int w;
        w = v & 255;
        if (w > EMAX) w -= 256;
        return w;
`endif
    endfunction

    function automatic bit clamps(input int v);
`ifdef MATRIX_COPROC_SAT_EN
        return (v > EMAX) || (v < EMIN);
`else
        return (v > EMAX) && (v < EMIN);
`endif
    endfunction

    function automatic logic [VW-1:0] pack(input int m[NE]);
        logic [VW-1:0] p;
        p = '0;
        for (int k = 0; k < NE; k++) p[k*EW +: EW] = EW'(m[k]);
        return p;
    endfunction

    // Reference: plain integer arithmetic over the active N x N window.
    function automatic exp_t model(input int op, input int n, input int a[NE], input int b[NE]);
        exp_t e;
        int   acc;
        int   v;
        int   k;
        int   d;
        e.res = '0; e.err = 1'b0; e.ovf = 1'b0; e.op = op; e.n = n; e.done_cyc = 0;
        acc = 0;
        if (!(op inside {0, 1, 3, 4, 7})) e.err = 1'b1;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                k = r*MN + c;
                d = k;
                v = 0;
                case (op)
                    0: v = a[k] + b[k];
                    1: v = a[k] - b[k];
                    3: begin v = a[k]; d = c*MN + r; end
                    4: v = -a[k];
                    7: acc += a[k] * b[k];
                    default: ;
                endcase
                if (op inside {0, 1, 3, 4}) begin
                    e.res[d*EW +: EW] = EW'(reduce(v));
                    if (clamps(v)) e.ovf = 1'b1;
                end
            end
        end
        if (op == 7) begin
            e.res[0 +: EW] = EW'(reduce(acc));
            if (clamps(acc)) e.ovf = 1'b1;
        end
        return e;
    endfunction

    task automatic set_inputs(input int op, input int size);
        op_code     = 3'(op);
        matrix_size = 2'(size);
        matrix_a    = pack(ma);
        matrix_b    = pack(mb);
    endtask

    task automatic scramble();
        matrix_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        matrix_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        op_code  = 3'($urandom_range(0, 7));
    endtask

    task automatic push_exp(input int op, input int size, input int accept_edge);
        exp_t e;
        int   n;
        n = (size + 2 > MN) ? MN : size + 2;
        e = model(op, n, ma, mb);
        e.done_cyc = accept_edge + n*n;
        exp_q.push_back(e);
    endtask

    // Called at the first negedge after the accept edge.
    task automatic wait_done(input int n, input bit extra);
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (process_Done) begin
                got = 1'b1;
            end else begin
                if (busy) cnt++;
                if (extra && i == 3) begin start = 1'b1; scramble(); end
                if (extra && i == 4) start = 1'b0;
                @(negedge clk);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL done_timeout actual=no_done required=done_within_80_cycles");
        end
        chk("busy_cycles", VW'(cnt), VW'(n*n));
    endtask

    task automatic run_op(input int op, input int size, input bit extra);
        int n;
        n = (size + 2 > MN) ? MN : size + 2;
        @(negedge clk);
        set_inputs(op, size);
        start = 1'b1;
        push_exp(op, size, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        scramble();
        wait_done(n, extra);
    endtask

    task automatic fill(input int av, input int bv);
        for (int k = 0; k < NE; k++) begin ma[k] = av; mb[k] = bv; end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && process_Done) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done actual=done_pulse required=no_pulse cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                txn++;
                $display("[TB] txn %0d op=%0d n=%0d cyc=%0d result=%0h err=%0b ovf=%0b",
                         txn, e.op, e.n, cyc, result_final, op_error, overflow);
                chk("result", result_final, e.res);
                chk("op_error", VW'(op_error), VW'(e.err));
                chk("overflow", VW'(overflow), VW'(e.ovf));
                chk("latency", VW'(cyc), VW'(e.done_cyc));
            end
        end
    end

    initial begin
        int op_pick;
        int n1;
        repeat (3) @(negedge clk);
        chk("reset_busy", VW'(busy), '0);
        chk("reset_done", VW'(process_Done), '0);
        chk("reset_result", result_final, '0);
        chk("reset_flags", VW'({op_error, overflow}), '0);
        reset = 1'b0;

        // Abort an N=5 add part-way through with an asynchronous reset.
        @(negedge clk);
        fill(1, 1);
        set_inputs(0, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_partial", VW'(result_final[0 +: EW]), VW'(2));
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", VW'(busy), '0);
        chk("abort_done", VW'(process_Done), '0);
        chk("abort_result", result_final, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle", VW'(busy), '0);

        fill(3, 4);       run_op(0, 0, 1'b0);
        fill(-100, 100);  run_op(1, 1, 1'b0);
        fill(2, 3);       run_op(7, 1, 1'b0);
        fill(127, 127);   run_op(7, 3, 1'b0);
        fill(-128, 0);    run_op(4, 0, 1'b0);
        fill(0, 0);
        ma[0*MN+1] = 5;
        ma[3*MN+2] = -7;
        run_op(3, 2, 1'b1);
        for (int k = 0; k < NE; k++) begin ma[k] = rnd_el(); mb[k] = rnd_el(); end
        run_op(2, 0, 1'b0);

        // start held high through DONE launches the next operation.
        @(negedge clk);
        fill(10, 20);
        set_inputs(0, 1);
        start = 1'b1;
        push_exp(0, 1, cyc + 1);
        @(negedge clk);
        fill(-5, 9);
        set_inputs(1, 0);
        wait_done(3, 1'b0);
        push_exp(1, 0, cyc + 2);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble();
        wait_done(2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < NE; k++) begin ma[k] = rnd_el(); mb[k] = rnd_el(); end
            op_pick = int'($urandom_range(0, 9));
            case (op_pick)
                0, 1:    op_pick = 0;
                2, 3:    op_pick = 1;
                4:       op_pick = 3;
                5, 6:    op_pick = 7;
                7:       op_pick = 4;
                default: op_pick = (t % 3 == 0) ? 2 : ((t % 3 == 1) ? 5 : 6);
            endcase
            n1 = int'($urandom_range(0, 3));
            run_op(op_pick, n1, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", VW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
